// File: rtl/alu_mul_seq_if.sv
// Bus between the control path / shared ALU and the multiply sequencer.
// The master side issues multiply requests and returns the ALU result.
// The slave side is the sequencer, which owns the ALU opcode and operands.
interface alu_mul_seq_if;
    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [3:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [31:0] alu_out;

    modport master (
        output start, op_a, op_b, alu_out,
        input  busy, done, result, alu_op, alu_a, alu_b
    );

    modport slave (
        input  start, op_a, op_b, alu_out,
        output busy, done, result, alu_op, alu_a, alu_b
    );
endinterface

// File: rtl/alu_mul_seq.sv
// Shift-and-add multiply sequencer: computes the low 32 bits of an unsigned
// 32x32 product by stepping the shared combinational ALU through ADD/SHL/SHR.
// No arithmetic lives here; every add and shift is done by the external ALU.
module alu_mul_seq (
    input  logic         clk,
    input  logic         rst_n,
    alu_mul_seq_if.slave bus
);

    localparam logic [3:0] AluAnd = 4'b0000;
    localparam logic [3:0] AluAdd = 4'b0100;
    localparam logic [3:0] AluShl = 4'b1010;
    localparam logic [3:0] AluShr = 4'b1011;

    typedef enum logic [2:0] {
        StIdle,
        StAdd,
        StShl,
        StShr,
        StFin
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] acc_q, acc_d;   // running partial product
    logic [31:0] mc_q, mc_d;     // multiplicand, shifted left each bit
    logic [31:0] mp_q, mp_d;     // multiplier, shifted right each bit

    logic [3:0]  alu_op;
    logic [31:0] alu_a;
    logic [31:0] alu_b;

    // Step selection for a remaining multiplier: done when no bits remain,
    // otherwise add the multiplicand if the LSB is set, else go straight to shifting.
    function automatic state_e next_step(input logic [31:0] m);
        if (m == 32'd0) begin
            return StFin;
        end else if (m[0]) begin
            return StAdd;
        end else begin
            return StShl;
        end
    endfunction

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            acc_q   <= 32'd0;
            mc_q    <= 32'd0;
            mp_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mc_q    <= mc_d;
            mp_q    <= mp_d;
        end
    end

    // Next-state, register updates and ALU drive, all decoded from the current state.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        mc_d    = mc_q;
        mp_d    = mp_q;
        alu_op  = AluAnd;
        alu_a   = 32'd0;
        alu_b   = 32'd0;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    acc_d   = 32'd0;
                    mc_d    = bus.op_a;
                    mp_d    = bus.op_b;
                    state_d = next_step(bus.op_b);
                end
            end
            StAdd: begin
                alu_op  = AluAdd;
                alu_a   = acc_q;
                alu_b   = mc_q;
                acc_d   = bus.alu_out;
                state_d = StShl;
            end
            StShl: begin
                alu_op  = AluShl;
                alu_a   = mc_q;
                alu_b   = 32'd1;
                mc_d    = bus.alu_out;
                state_d = StShr;
            end
            StShr: begin
                alu_op  = AluShr;
                alu_a   = mp_q;
                alu_b   = 32'd1;
                mp_d    = bus.alu_out;
                // Decide on the shifted multiplier the ALU is producing this cycle.
                state_d = next_step(bus.alu_out);
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign bus.busy   = (state_q != StIdle);
    assign bus.done   = (state_q == StFin);
    assign bus.result = acc_q;
    assign bus.alu_op = alu_op;
    assign bus.alu_a  = alu_a;
    assign bus.alu_b  = alu_b;

    // done is a sub-phase of busy, and the ALU is left idle-driven outside active steps.
    a_done_busy: assert property (@(posedge clk) disable iff (!rst_n) bus.done |-> bus.busy);
    a_idle_alu: assert property (@(posedge clk) disable iff (!rst_n)
        (!bus.busy || bus.done) |-> (alu_op == AluAnd && alu_a == 32'd0 && alu_b == 32'd0));

endmodule

// File: tb/tb_alu_mul_seq.sv
// Randomized scoreboard bench for alu_mul_seq with a behavioural ALU.
module tb_alu_mul_seq;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
    } step_t;

    typedef struct packed {
        logic [31:0] res;
        logic [31:0] cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;

    alu_mul_seq_if bus ();

    alu_mul_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Shared ALU model.
    always_comb begin
        case (bus.alu_op)
            4'b0000: bus.alu_out = bus.alu_a & bus.alu_b;
            4'b0100: bus.alu_out = bus.alu_a + bus.alu_b;
            4'b1010: bus.alu_out = bus.alu_a << bus.alu_b[4:0];
            4'b1011: bus.alu_out = bus.alu_a >> bus.alu_b[4:0];
            default: bus.alu_out = 32'd0;
        endcase
    end

    step_t       exp_steps[$];
    exp_t        exp_q[$];
    logic [31:0] cyc = 32'd0;
    int          checks = 0;
    int          errors = 0;
    int          tmo_cnt = 0;
    logic        end_req = 1'b0;
    logic [31:0] last_res = 32'd0;

    always @(posedge clk) cyc <= cyc + 32'd1;

    function automatic void check(input string name, input logic [31:0] got,
                                  input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%h want=%h", name, got, want);
        end
    endfunction

    function automatic void fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s got=event want=none", name);
    endfunction

    // Reference: bit i of the multiplier costs an ADD (if set) plus SHL and SHR,
    // for every bit up to the highest set one.
    function automatic void push_expect(input logic [31:0] a, input logic [31:0] b,
                                        input logic [31:0] c0);
        logic [31:0] sum = 32'd0;
        logic [31:0] n = 32'd0;
        exp_t e;
        for (int i = 0; i < 32; i++) begin
            if ((b >> i) == 32'd0) break;
            if (b[i]) begin
                exp_steps.push_back('{op: 4'b0100, a: sum, b: a << i});
                sum = sum + (a << i);
                n++;
            end
            exp_steps.push_back('{op: 4'b1010, a: a << i, b: 32'd1});
            exp_steps.push_back('{op: 4'b1011, a: b >> i, b: 32'd1});
            n = n + 32'd2;
        end
        e.res = a * b;
        e.cyc = c0 + n + 32'd1;
        exp_q.push_back(e);
    endfunction

    // Monitor: pops the scoreboard as the DUT steps and finishes.
    always @(negedge clk) begin
        step_t s;
        exp_t  e;
        if (!rst_n) begin
            exp_steps.delete();
            exp_q.delete();
            last_res = 32'd0;
            check("rst_busy", 32'(bus.busy), 32'd0);
            check("rst_done", 32'(bus.done), 32'd0);
            check("rst_result", bus.result, 32'd0);
            check("rst_alu_op", 32'(bus.alu_op), 32'd0);
            check("rst_alu_a", bus.alu_a, 32'd0);
            check("rst_alu_b", bus.alu_b, 32'd0);
        end else begin
            if (bus.busy && !bus.done) begin
                if (exp_steps.size() == 0) begin
                    fail_now("step_unexpected");
                end else begin
                    s = exp_steps.pop_front();
                    check("step_alu_op", 32'(bus.alu_op), 32'(s.op));
                    check("step_alu_a", bus.alu_a, s.a);
                    check("step_alu_b", bus.alu_b, s.b);
                end
            end
            if (bus.done) begin
                check("fin_busy", 32'(bus.busy), 32'd1);
                check("fin_alu_op", 32'(bus.alu_op), 32'd0);
                check("fin_alu_a", bus.alu_a, 32'd0);
                check("fin_alu_b", bus.alu_b, 32'd0);
                if (exp_q.size() == 0) begin
                    fail_now("done_unexpected");
                end else begin
                    e = exp_q.pop_front();
                    check("done_result", bus.result, e.res);
                    check("done_cycle", cyc, e.cyc);
                    last_res = e.res;
                end
            end
            if (!bus.busy) begin
                check("idle_done", 32'(bus.done), 32'd0);
                check("idle_alu_op", 32'(bus.alu_op), 32'd0);
                check("idle_alu_a", bus.alu_a, 32'd0);
                check("idle_alu_b", bus.alu_b, 32'd0);
                check("idle_result_held", bus.result, last_res);
            end
        end
        if (end_req) begin
            check("pending_results", 32'(exp_q.size()), 32'd0);
            check("pending_steps", 32'(exp_steps.size()), 32'd0);
            check("wait_timeouts", 32'(tmo_cnt), 32'd0);
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $finish;
        end
    end

    // Wait for IDLE (bounded), present one request for one clock edge.
    task automatic issue(input logic [31:0] a, input logic [31:0] b);
        int w = 0;
        @(negedge clk);
        while (bus.busy && w < 400) begin
            @(negedge clk);
            w++;
        end
        if (bus.busy) begin
            tmo_cnt++;
            return;
        end
        bus.start = 1'b1;
        bus.op_a  = a;
        bus.op_b  = b;
        push_expect(a, b, cyc);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.op_a  = $urandom;
        bus.op_b  = $urandom;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "global timeout");
    end

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        int w;
        rst_n     = 1'b1;
        bus.start = 1'b0;
        bus.op_a  = 32'd0;
        bus.op_b  = 32'd0;
        #1 rst_n = 1'b0;
        // Random inputs must not disturb the reset state.
        repeat (6) begin
            @(negedge clk);
            bus.start = 1'($urandom);
            bus.op_a  = $urandom;
            bus.op_b  = $urandom;
        end
        bus.start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;

        issue(32'd3, 32'd5);
        issue(32'h12345678, 32'd0);
        issue(32'd7, 32'd1);
        issue(32'hFFFFFFFF, 32'hFFFFFFFF);

        // Start held high throughout, operands churning: only the first request counts.
        @(negedge clk);
        w = 0;
        while (bus.busy && w < 400) begin
            @(negedge clk);
            w++;
        end
        bus.start = 1'b1;
        bus.op_a  = 32'd2;
        bus.op_b  = 32'd3;
        push_expect(32'd2, 32'd3, cyc);
        w = 0;
        do begin
            @(negedge clk);
            w++;
            if (!bus.done) begin
                bus.op_a = $urandom;
                bus.op_b = $urandom;
            end
        end while (!bus.done && w < 50);
        if (!bus.done) tmo_cnt++;
        bus.op_a = 32'd11;
        bus.op_b = 32'd6;
        @(negedge clk);
        if (bus.busy) tmo_cnt++;
        else push_expect(32'd11, 32'd6, cyc);
        @(posedge clk);
        #1 bus.start = 1'b0;

        // Abort mid-operation with reset; no done may follow.
        issue(32'd9, 32'h80);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b1;
        issue(32'd9, 32'd2);

        issue($urandom, 32'h80000000);
        issue(32'd0, $urandom);
        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(ra, rb);
        end

        w = 0;
        while ((exp_q.size() != 0 || bus.busy) && w < 400) begin
            @(negedge clk);
            w++;
        end
        if (exp_q.size() != 0) tmo_cnt++;
        repeat (2) @(negedge clk);
        end_req = 1'b1;
    end

endmodule
